id_ex_stage_reg: RTL and testbench
==================================

Name: id_ex_stage_reg

Overview:
- ID/EX pipeline register of the 5-stage MIPS pipeline. Sits directly downstream of the load-use hazard detector and consumes its `loaduse` flag.
- On a load-use hazard it freezes PC and IF/ID and injects one bubble into EX. On a taken branch/jump it flushes (bubbles) EX.
- Holds the whole pipe on halt (syscall stop).
- Keeps wrap-around counters of load-use stalls and flushes for the CPI statistics display.

Parameters:
- DATA_W, 32, width of PC, instruction, operand and immediate fields
- CNT_W, 16, width of each statistics counter

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- loaduse  in  1  load-use hazard flag from the hazard detector (combinational, same cycle)
- flush  in  1  branch/jump taken, resolved in EX
- halt  in  1  syscall halt; freezes all pipeline state
- pc_id  in  DATA_W  PC of instruction in ID
- ir_id  in  DATA_W  instruction word in ID
- ra_data_id, rb_data_id  in  DATA_W  register-file read data
- imm_id  in  DATA_W  extended immediate
- ra_id, rb_id, rd_id  in  5  source/destination register numbers
- op_id, func_id  in  6  opcode / function field
- ctrl_id  in  8  control word {we, alusrc, memtoreg, memwrite, branch, jump, syscall, shamt_sel}
- pc_ex, ir_ex, ra_data_ex, rb_data_ex, imm_ex  out  DATA_W  registered EX fields
- ra_ex, rb_ex, rd_ex  out  5  registered register numbers
- op_ex, func_ex  out  6  registered opcode/function
- ctrl_ex  out  8  registered control word (bit 7 = we_ex)
- valid_ex  out  1  EX holds a real instruction
- pc_en  out  1  PC write enable (combinational)
- ifid_en  out  1  IF/ID write enable (combinational)
- loaduse_cnt  out  CNT_W  number of bubbles caused by load-use
- flush_cnt  out  CNT_W  number of flush cycles

Behaviour:
- Reset: on the rising edge with rst_n=0, all EX outputs are cleared (0), valid_ex=0, both counters=0. Reset wins over every other input, including mid-halt and mid-stall.
- Per-edge priority, rst_n=1:
  1. halt: all registers and counters hold.
  2. flush or loaduse: bubble is loaded.
  3. Otherwise: all *_id fields load into *_ex and valid_ex=1.
- Bubble contents:
  - ctrl_ex=0, rd_ex=0, ra_ex=0, rb_ex=0, op_ex=0, func_ex=0, ir_ex=0 (nop), valid_ex=0.
  - pc_ex takes pc_id so the debug trace remains monotonic.
  - Data fields are cleared to 0.
- Stall enables:
  - pc_en = ifid_en = rst_n & ~halt & ~(loaduse & ~flush).
  - A flush overrides a stall: the wrong-path instruction in ID is discarded, so the fetch must proceed.
- Latency: 1 cycle from ID inputs to EX outputs.
- Hazard duration: a bubble sets we_ex=0 and rd_ex=0, so `loaduse` deasserts the next cycle. The stall is therefore exactly 1 cycle per hazard.
- Counters (no halt, rst_n=1):
  - loaduse_cnt += 1 on each edge with loaduse & ~flush.
  - flush_cnt += 1 on each edge with flush.
  - Simultaneous loaduse and flush: only flush_cnt increments.
  - Both counters wrap modulo 2^CNT_W, with no saturation.
- Halt released: operation resumes the next edge with no lost or duplicated instruction.
- loaduse asserted during halt: no bubble, no count. The hazard is re-evaluated after release.

Decomposition:
- Shared package `mips_pkg` holds:
  - opcode/func constants (OP_RTYPE, OP_LW 0x23, OP_SW 0x2b, OP_BEQ 0x04, OP_BNE 0x05, OP_J 0x02, OP_JAL 0x03, FN_SYSCALL 0x0c)
  - control-word bit indices
  - CTRL_BUBBLE = 8'h00
- One sub-module `event_counter` (CNT_W parameter, enable, synchronous active-low clear, wrap) is instantiated twice.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with ID fields = 0xFFFFFFFF. Required: all EX outputs 0, valid_ex=0, counters 0, pc_en=0.
- Normal flow: pc_id=0x00003000, ir_id=0x00851020 (add $2,$4,$5), ctrl we=1. One edge later: pc_ex=0x3000, rd_ex=2, ctrl_ex[7]=1, valid_ex=1, pc_en=1.
- Load-use: EX holds lw $8 (rd_ex=8, we=1); detector drives loaduse=1 for one cycle. Required:
  - pc_en=ifid_en=0 in that cycle.
  - Next edge: ctrl_ex=0, rd_ex=0, valid_ex=0, loaduse_cnt=1.
  - Following edge: the add enters EX with pc_en=1.
- Simultaneous: loaduse=1 and flush=1 in the same cycle. Required: pc_en=1, bubble loaded, flush_cnt=1, loaduse_cnt=0.
- Halt: halt=1 for 3 cycles while loaduse=1. Required: EX outputs and counters unchanged, pc_en=0. After release with loaduse=0: the next instruction loads normally.
- Wrap: CNT_W=4; apply 17 flush edges. Required: flush_cnt=1. Then pulse rst_n=0 mid-sequence. Required: counters 0 on that edge.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: opcode/func encodings, control-word layout, bubble value.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE   = 6'h00;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2b;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] FN_SYSCALL = 6'h0c;

  // Control word {we, alusrc, memtoreg, memwrite, branch, jump, syscall, shamt_sel}
  localparam int unsigned CTRL_WE        = 7;
  localparam int unsigned CTRL_ALUSRC    = 6;
  localparam int unsigned CTRL_MEMTOREG  = 5;
  localparam int unsigned CTRL_MEMWRITE  = 4;
  localparam int unsigned CTRL_BRANCH    = 3;
  localparam int unsigned CTRL_JUMP      = 2;
  localparam int unsigned CTRL_SYSCALL   = 1;
  localparam int unsigned CTRL_SHAMT_SEL = 0;

  localparam logic [7:0] CTRL_BUBBLE = 8'h00;

endpackage

// File: rtl/event_counter.sv
// Wrap-around event counter with enable and synchronous active-low clear.
module event_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_clr_n,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_clr_n) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: bubble injection on load-use or flush, halt freeze,
// combinational PC/IF-ID stall enables and stall/flush statistics counters.
module id_ex_stage_reg
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              loaduse,
  input  logic              flush,
  input  logic              halt,
  input  logic [DATA_W-1:0] pc_id,
  input  logic [DATA_W-1:0] ir_id,
  input  logic [DATA_W-1:0] ra_data_id,
  input  logic [DATA_W-1:0] rb_data_id,
  input  logic [DATA_W-1:0] imm_id,
  input  logic [4:0]        ra_id,
  input  logic [4:0]        rb_id,
  input  logic [4:0]        rd_id,
  input  logic [5:0]        op_id,
  input  logic [5:0]        func_id,
  input  logic [7:0]        ctrl_id,
  output logic [DATA_W-1:0] pc_ex,
  output logic [DATA_W-1:0] ir_ex,
  output logic [DATA_W-1:0] ra_data_ex,
  output logic [DATA_W-1:0] rb_data_ex,
  output logic [DATA_W-1:0] imm_ex,
  output logic [4:0]        ra_ex,
  output logic [4:0]        rb_ex,
  output logic [4:0]        rd_ex,
  output logic [5:0]        op_ex,
  output logic [5:0]        func_ex,
  output logic [7:0]        ctrl_ex,
  output logic              valid_ex,
  output logic              pc_en,
  output logic              ifid_en,
  output logic [CNT_W-1:0]  loaduse_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  logic [DATA_W-1:0] r_pc, r_ir, r_ra_data, r_rb_data, r_imm;
  logic [4:0]        r_ra, r_rb, r_rd;
  logic [5:0]        r_op, r_func;
  logic [7:0]        r_ctrl;
  logic              r_valid;

  logic w_bubble;
  logic w_lu_stall;

  assign w_bubble   = flush | loaduse;
  // A flush discards the instruction in ID, so it cancels the load-use stall.
  assign w_lu_stall = loaduse & ~flush;

  assign pc_en   = rst_n & ~halt & ~w_lu_stall;
  assign ifid_en = rst_n & ~halt & ~w_lu_stall;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc      <= '0;
      r_ir      <= '0;
      r_ra_data <= '0;
      r_rb_data <= '0;
      r_imm     <= '0;
      r_ra      <= '0;
      r_rb      <= '0;
      r_rd      <= '0;
      r_op      <= '0;
      r_func    <= '0;
      r_ctrl    <= CTRL_BUBBLE;
      r_valid   <= 1'b0;
    end else if (halt) begin
      r_valid <= r_valid;
    end else if (w_bubble) begin
      // pc still advances so the debug trace stays monotonic.
      r_pc      <= pc_id;
      r_ir      <= '0;
      r_ra_data <= '0;
      r_rb_data <= '0;
      r_imm     <= '0;
      r_ra      <= '0;
      r_rb      <= '0;
      r_rd      <= '0;
      r_op      <= '0;
      r_func    <= '0;
      r_ctrl    <= CTRL_BUBBLE;
      r_valid   <= 1'b0;
    end else begin
      r_pc      <= pc_id;
      r_ir      <= ir_id;
      r_ra_data <= ra_data_id;
      r_rb_data <= rb_data_id;
      r_imm     <= imm_id;
      r_ra      <= ra_id;
      r_rb      <= rb_id;
      r_rd      <= rd_id;
      r_op      <= op_id;
      r_func    <= func_id;
      r_ctrl    <= ctrl_id;
      r_valid   <= 1'b1;
    end
  end

  assign pc_ex      = r_pc;
  assign ir_ex      = r_ir;
  assign ra_data_ex = r_ra_data;
  assign rb_data_ex = r_rb_data;
  assign imm_ex     = r_imm;
  assign ra_ex      = r_ra;
  assign rb_ex      = r_rb;
  assign rd_ex      = r_rd;
  assign op_ex      = r_op;
  assign func_ex    = r_func;
  assign ctrl_ex    = r_ctrl;
  assign valid_ex   = r_valid;

  logic w_lu_cnt_en;
  logic w_fl_cnt_en;

  assign w_lu_cnt_en = ~halt & w_lu_stall;
  assign w_fl_cnt_en = ~halt & flush;

  event_counter #(
    .CNT_W(CNT_W)
  ) u_loaduse_cnt (
    .i_clk  (clk),
    .i_clr_n(rst_n),
    .i_en   (w_lu_cnt_en),
    .o_cnt  (loaduse_cnt)
  );

  event_counter #(
    .CNT_W(CNT_W)
  ) u_flush_cnt (
    .i_clk  (clk),
    .i_clr_n(rst_n),
    .i_en   (w_fl_cnt_en),
    .o_cnt  (flush_cnt)
  );

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed bench for id_ex_stage_reg with 4-bit counters so wrap-around is reachable.
module tb_id_ex_stage_reg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst_n, loaduse, flush, halt;
  logic [DATA_W-1:0] pc_id, ir_id, ra_data_id, rb_data_id, imm_id;
  logic [4:0]        ra_id, rb_id, rd_id;
  logic [5:0]        op_id, func_id;
  logic [7:0]        ctrl_id;
  logic [DATA_W-1:0] pc_ex, ir_ex, ra_data_ex, rb_data_ex, imm_ex;
  logic [4:0]        ra_ex, rb_ex, rd_ex;
  logic [5:0]        op_ex, func_ex;
  logic [7:0]        ctrl_ex;
  logic              valid_ex, pc_en, ifid_en;
  logic [CNT_W-1:0]  loaduse_cnt, flush_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  id_ex_stage_reg #(
    .DATA_W(DATA_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .loaduse    (loaduse),
    .flush      (flush),
    .halt       (halt),
    .pc_id      (pc_id),
    .ir_id      (ir_id),
    .ra_data_id (ra_data_id),
    .rb_data_id (rb_data_id),
    .imm_id     (imm_id),
    .ra_id      (ra_id),
    .rb_id      (rb_id),
    .rd_id      (rd_id),
    .op_id      (op_id),
    .func_id    (func_id),
    .ctrl_id    (ctrl_id),
    .pc_ex      (pc_ex),
    .ir_ex      (ir_ex),
    .ra_data_ex (ra_data_ex),
    .rb_data_ex (rb_data_ex),
    .imm_ex     (imm_ex),
    .ra_ex      (ra_ex),
    .rb_ex      (rb_ex),
    .rd_ex      (rd_ex),
    .op_ex      (op_ex),
    .func_ex    (func_ex),
    .ctrl_ex    (ctrl_ex),
    .valid_ex   (valid_ex),
    .pc_en      (pc_en),
    .ifid_en    (ifid_en),
    .loaduse_cnt(loaduse_cnt),
    .flush_cnt  (flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic [31:0] pc, input logic [31:0] ir, input logic [7:0] ctrl,
                        input logic [31:0] rad, input logic [31:0] rbd, input logic [31:0] imm);
    pc_id      = pc;
    ir_id      = ir;
    op_id      = ir[31:26];
    ra_id      = ir[25:21];
    rb_id      = ir[20:16];
    rd_id      = (ir[31:26] == 6'h00) ? ir[15:11] : ir[20:16];
    func_id    = ir[5:0];
    ctrl_id    = ctrl;
    ra_data_id = rad;
    rb_data_id = rbd;
    imm_id     = imm;
  endtask

  initial begin
    rst_n = 1'b0; loaduse = 1'b0; flush = 1'b0; halt = 1'b0;
    pc_id = '1; ir_id = '1; ra_data_id = '1; rb_data_id = '1; imm_id = '1;
    ra_id = '1; rb_id = '1; rd_id = '1; op_id = '1; func_id = '1; ctrl_id = '1;
    step();
    step();
    chk("rst_pc_ex", pc_ex, 0);
    chk("rst_ir_ex", ir_ex, 0);
    chk("rst_radata", ra_data_ex, 0);
    chk("rst_imm", imm_ex, 0);
    chk("rst_rd_ex", {27'd0, rd_ex}, 0);
    chk("rst_ctrl", {24'd0, ctrl_ex}, 0);
    chk("rst_valid", {31'd0, valid_ex}, 0);
    chk("rst_lucnt", {28'd0, loaduse_cnt}, 0);
    chk("rst_flcnt", {28'd0, flush_cnt}, 0);
    chk("rst_pc_en", {31'd0, pc_en}, 0);

    // Normal flow: add $2,$4,$5
    rst_n = 1'b1;
    set_id(32'h3000, 32'h0085_1020, 8'h80, 32'd11, 32'd22, 32'h1020);
    #1;
    chk("nrm_pc_en", {31'd0, pc_en}, 1);
    step();
    chk("nrm_pc_ex", pc_ex, 32'h3000);
    chk("nrm_rd_ex", {27'd0, rd_ex}, 2);
    chk("nrm_we_ex", {31'd0, ctrl_ex[7]}, 1);
    chk("nrm_valid", {31'd0, valid_ex}, 1);
    chk("nrm_radata", ra_data_ex, 11);
    chk("nrm_func", {26'd0, func_ex}, 32'h20);

    // lw $8,0($4) enters EX
    set_id(32'h3004, 32'h8C88_0000, 8'hE0, 32'd33, 32'd0, 32'd0);
    step();
    chk("lw_rd_ex", {27'd0, rd_ex}, 8);
    chk("lw_op_ex", {26'd0, op_ex}, 32'h23);

    // add $2,$8,$5 in ID depends on the load
    set_id(32'h3008, 32'h0105_1020, 8'h80, 32'd44, 32'd55, 32'h1020);
    loaduse = 1'b1;
    #1;
    chk("lu_pc_en", {31'd0, pc_en}, 0);
    chk("lu_ifid_en", {31'd0, ifid_en}, 0);
    step();
    loaduse = 1'b0;
    chk("lu_ctrl", {24'd0, ctrl_ex}, 0);
    chk("lu_rd_ex", {27'd0, rd_ex}, 0);
    chk("lu_valid", {31'd0, valid_ex}, 0);
    chk("lu_ir_ex", ir_ex, 0);
    chk("lu_radata", ra_data_ex, 0);
    chk("lu_pc_ex", pc_ex, 32'h3008);
    chk("lu_cnt", {28'd0, loaduse_cnt}, 1);
    #1;
    chk("lu_rel_pc_en", {31'd0, pc_en}, 1);
    step();
    chk("lu_add_ir", ir_ex, 32'h0105_1020);
    chk("lu_add_valid", {31'd0, valid_ex}, 1);
    chk("lu_cnt_hold", {28'd0, loaduse_cnt}, 1);

    // Reset mid-run clears counters
    rst_n = 1'b0;
    step();
    chk("rst2_lucnt", {28'd0, loaduse_cnt}, 0);
    chk("rst2_valid", {31'd0, valid_ex}, 0);

    // Simultaneous loaduse and flush
    rst_n = 1'b1;
    set_id(32'h300C, 32'h0085_1020, 8'h80, 32'd1, 32'd2, 32'd3);
    loaduse = 1'b1;
    flush = 1'b1;
    #1;
    chk("sim_pc_en", {31'd0, pc_en}, 1);
    step();
    loaduse = 1'b0;
    flush = 1'b0;
    chk("sim_valid", {31'd0, valid_ex}, 0);
    chk("sim_ctrl", {24'd0, ctrl_ex}, 0);
    chk("sim_pc_ex", pc_ex, 32'h300C);
    chk("sim_flcnt", {28'd0, flush_cnt}, 1);
    chk("sim_lucnt", {28'd0, loaduse_cnt}, 0);

    // Halt with loaduse asserted: everything freezes
    set_id(32'h3010, 32'h00A6_3820, 8'h80, 32'd7, 32'd8, 32'd9);
    step();
    chk("pre_halt_pc", pc_ex, 32'h3010);
    halt = 1'b1;
    loaduse = 1'b1;
    flush = 1'b1;
    set_id(32'h3014, 32'h0107_4820, 8'h80, 32'd70, 32'd80, 32'd90);
    #1;
    chk("halt_pc_en", {31'd0, pc_en}, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("halt_pc_ex", pc_ex, 32'h3010);
      chk("halt_ir_ex", ir_ex, 32'h00A6_3820);
      chk("halt_valid", {31'd0, valid_ex}, 1);
      chk("halt_lucnt", {28'd0, loaduse_cnt}, 0);
      chk("halt_flcnt", {28'd0, flush_cnt}, 1);
    end
    halt = 1'b0;
    loaduse = 1'b0;
    flush = 1'b0;
    step();
    chk("rel_pc_ex", pc_ex, 32'h3014);
    chk("rel_ir_ex", ir_ex, 32'h0107_4820);
    chk("rel_radata", ra_data_ex, 70);
    chk("rel_valid", {31'd0, valid_ex}, 1);

    // Flush counter wrap at 4 bits
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    flush = 1'b1;
    for (int i = 0; i < 17; i++) begin
      step();
      if (i == 15) chk("wrap_16", {28'd0, flush_cnt}, 0);
    end
    chk("wrap_17", {28'd0, flush_cnt}, 1);
    chk("wrap_lucnt", {28'd0, loaduse_cnt}, 0);
    chk("wrap_valid", {31'd0, valid_ex}, 0);
    step();
    step();
    chk("wrap_19", {28'd0, flush_cnt}, 3);
    rst_n = 1'b0;
    step();
    chk("wrap_rst_fl", {28'd0, flush_cnt}, 0);
    chk("wrap_rst_lu", {28'd0, loaduse_cnt}, 0);
    chk("wrap_rst_pc", pc_ex, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
